// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and state encoding for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_D_BUSY = 3'd1,
      S_I_BUSY = 3'd2,
      S_D_DONE = 3'd3,
      S_I_DONE = 3'd4,
      S_DRAIN  = 3'd5
   } state_t;

   localparam logic        ChipEnable      = 1'b1;
   localparam logic        WriteEnable     = 1'b1;
   localparam logic        RstEnable       = 1'b0;
   localparam logic [31:0] ZeroWord        = 32'h0000_0000;
   localparam logic [3:0]  SelWord         = 4'b1111;
   localparam int          DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Busy-cycle counter that flags the last cycle a bus transaction may wait for ack.
module mem_bus_watchdog
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] count_r;

   // Counts busy cycles already elapsed; saturates so it never wraps back to zero
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         count_r <= 8'd0;
      end else if (clr) begin
         count_r <= 8'd0;
      end else if (en && (count_r != 8'hFF)) begin
         count_r <= count_r + 8'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign expire = en && (count_r == LAST_CYCLE);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-style port between instruction fetch and MEM data access,
// stalling each requester until its multi-cycle bus transaction completes.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_ce_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_data_o,
   output logic              if_stallreq_o,
   input  logic              mem_ce_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [3:0]        mem_sel_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              mem_stallreq_o,
   input  logic              flush_i,
   output logic              bus_cyc_o,
   output logic              bus_stb_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_sel_o,
   output logic [DATA_W-1:0] bus_data_o,
   input  logic [DATA_W-1:0] bus_data_i,
   input  logic              bus_ack_i,
   output logic              bus_err_o
);

   state_t              state_r;
   logic                flush_pend_r;
   logic                bus_cyc_r;
   logic                bus_we_r;
   logic [ADDR_W-1:0]   bus_addr_r;
   logic [3:0]          bus_sel_r;
   logic [DATA_W-1:0]   bus_data_r;
   logic [DATA_W-1:0]   if_data_r;
   logic [DATA_W-1:0]   mem_data_r;
   logic                bus_err_r;
   logic                busy_s;
   logic                expire_s;
   logic                finish_s;
   logic                drop_s;
   logic [DATA_W-1:0]   result_s;

   assign busy_s   = (state_r == S_D_BUSY) || (state_r == S_I_BUSY);
   assign finish_s = busy_s && (bus_ack_i || expire_s);
   assign drop_s   = flush_pend_r || flush_i;
   assign result_s = bus_ack_i ? bus_data_i : DATA_W'(ZeroWord);

   mem_bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (!busy_s),
      .en     (busy_s),
      .expire (expire_s)
   );

   // Arbitration FSM; a flushed transaction still finishes on the bus but its result is dropped
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_r      <= S_IDLE;
         flush_pend_r <= 1'b0;
         bus_cyc_r    <= 1'b0;
         bus_we_r     <= 1'b0;
         bus_addr_r   <= '0;
         bus_sel_r    <= 4'b0000;
         bus_data_r   <= '0;
         if_data_r    <= '0;
         mem_data_r   <= '0;
         bus_err_r    <= 1'b0;
      end else begin
         bus_err_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               flush_pend_r <= 1'b0;
               if (flush_i) begin
                  state_r <= S_IDLE;
               end else if (mem_ce_i == ChipEnable) begin
                  state_r    <= S_D_BUSY;
                  bus_cyc_r  <= 1'b1;
                  bus_we_r   <= (mem_we_i == WriteEnable);
                  bus_addr_r <= mem_addr_i;
                  bus_sel_r  <= mem_sel_i;
                  bus_data_r <= mem_data_i;
               end else if (if_ce_i == ChipEnable) begin
                  state_r    <= S_I_BUSY;
                  bus_cyc_r  <= 1'b1;
                  bus_we_r   <= 1'b0;
                  bus_addr_r <= if_addr_i;
                  bus_sel_r  <= SelWord;
                  bus_data_r <= DATA_W'(ZeroWord);
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_D_BUSY, S_I_BUSY: begin
               if (finish_s) begin
                  bus_cyc_r    <= 1'b0;
                  flush_pend_r <= 1'b0;
                  bus_err_r    <= !bus_ack_i;
                  if (drop_s) begin
                     state_r <= S_IDLE;
                  end else if (state_r == S_D_BUSY) begin
                     state_r    <= S_D_DONE;
                     mem_data_r <= result_s;
                  end else begin
                     state_r   <= S_I_DONE;
                     if_data_r <= result_s;
                  end
               end else begin
                  flush_pend_r <= drop_s;
               end
            end
            S_D_DONE, S_I_DONE: begin
               state_r <= flush_i ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
               state_r <= S_IDLE;
            end
            default: begin
               state_r   <= S_IDLE;
               bus_cyc_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus_cyc_o  = bus_cyc_r;
   assign bus_stb_o  = bus_cyc_r;
   assign bus_we_o   = bus_we_r;
   assign bus_addr_o = bus_addr_r;
   assign bus_sel_o  = bus_sel_r;
   assign bus_data_o = bus_data_r;
   assign bus_err_o  = bus_err_r;
   assign if_data_o  = if_data_r;
   assign mem_data_o = mem_data_r;

   assign mem_stallreq_o = (rst != RstEnable) && (mem_ce_i == ChipEnable) && (state_r != S_D_DONE);
   assign if_stallreq_o  = (rst != RstEnable) && (if_ce_i == ChipEnable) && (state_r != S_I_DONE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

   localparam int TO = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_ce_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        if_stallreq_o;
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [31:0] mem_addr_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;
   logic        mem_stallreq_o;
   logic        flush_i;
   logic        bus_cyc_o;
   logic        bus_stb_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_data_o;
   logic [31:0] bus_data_i;
   logic        bus_ack_i;
   logic        bus_err_o;

   int checks   = 0;
   int failures = 0;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_stallreq_o(if_stallreq_o),
      .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
      .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_stallreq_o(mem_stallreq_o),
      .flush_i(flush_i), .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
      .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_data_o(bus_data_o),
      .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s got=%0h want=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: one outstanding access, its elapsed bus cycles, and whether it was flushed
   logic        m_active  = 1'b0;
   logic        m_is_data = 1'b0;
   logic        m_flushed = 1'b0;
   int          m_elapsed = 0;
   int          m_done    = 0;
   logic        m_drain   = 1'b0;
   logic        m_err     = 1'b0;
   logic        m_we      = 1'b0;
   logic [31:0] m_addr    = 32'h0;
   logic [3:0]  m_sel     = 4'h0;
   logic [31:0] m_data    = 32'h0;
   logic [31:0] e_mem     = 32'h0;
   logic [31:0] e_if      = 32'h0;

   always @(negedge clk) begin
      logic [31:0] res;
      check("bus_cyc", 64'(bus_cyc_o), 64'(m_active));
      check("bus_stb", 64'(bus_stb_o), 64'(m_active));
      if (m_active) begin
         check("bus_we", 64'(bus_we_o), 64'(m_we));
         check("bus_addr", 64'(bus_addr_o), 64'(m_addr));
         check("bus_sel", 64'(bus_sel_o), 64'(m_sel));
         if (m_is_data) check("bus_data", 64'(bus_data_o), 64'(m_data));
      end
      check("bus_err", 64'(bus_err_o), 64'(m_err));
      check("mem_data", 64'(mem_data_o), 64'(e_mem));
      check("if_data", 64'(if_data_o), 64'(e_if));
      check("mem_stall", 64'(mem_stallreq_o), 64'(rst && mem_ce_i && (m_done != 1)));
      check("if_stall", 64'(if_stallreq_o), 64'(rst && if_ce_i && (m_done != 2)));
      // Inputs are stable from here to the next rising edge, so advance the model now
      if (rst == 1'b0) begin
         m_active = 1'b0; m_done = 0; m_drain = 1'b0; m_err = 1'b0;
         m_flushed = 1'b0; e_mem = 32'h0; e_if = 32'h0;
      end else begin
         m_err = 1'b0;
         if (m_active) begin
            m_elapsed++;
            if (flush_i) m_flushed = 1'b1;
            if (bus_ack_i || (m_elapsed >= TO)) begin
               res      = bus_ack_i ? bus_data_i : 32'h0;
               m_err    = !bus_ack_i;
               m_active = 1'b0;
               if (!m_flushed) begin
                  if (m_is_data) begin e_mem = res; m_done = 1; end
                  else begin e_if = res; m_done = 2; end
               end
            end
         end else if (m_done != 0) begin
            m_drain = flush_i;
            m_done  = 0;
         end else if (m_drain) begin
            m_drain = 1'b0;
         end else if (!flush_i && (mem_ce_i || if_ce_i)) begin
            m_active  = 1'b1;
            m_elapsed = 0;
            m_flushed = 1'b0;
            m_is_data = mem_ce_i;
            m_we      = mem_ce_i ? mem_we_i : 1'b0;
            m_addr    = mem_ce_i ? mem_addr_i : if_addr_i;
            m_sel     = mem_ce_i ? mem_sel_i : 4'hF;
            m_data    = mem_data_i;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst = 1'b0; if_ce_i = 1'b0; if_addr_i = 32'h0; mem_ce_i = 1'b1; mem_we_i = 1'b0;
      mem_addr_i = 32'h10; mem_sel_i = 4'hF; mem_data_i = 32'h0; flush_i = 1'b0;
      bus_data_i = 32'h0; bus_ack_i = 1'b0;

      // Reset held with a pending data request
      for (int i = 0; i < 3; i++) begin
         step;
         @(negedge clk);
         check("rst_cyc", 64'(bus_cyc_o), 64'd0);
         check("rst_we_sel", 64'({bus_we_o, bus_sel_o}), 64'd0);
         check("rst_addr_data", 64'({bus_addr_o, bus_data_o}), 64'd0);
         check("rst_stalls", 64'({mem_stallreq_o, if_stallreq_o, bus_err_o}), 64'd0);
         check("rst_results", 64'({mem_data_o, if_data_o}), 64'd0);
      end
      step; rst = 1'b1;
      @(negedge clk); check("rel_idle", 64'(bus_cyc_o), 64'd0);
      step; bus_ack_i = 1'b1; bus_data_i = 32'h11;
      @(negedge clk); check("rel_busy", 64'(bus_cyc_o), 64'd1);
      step; mem_ce_i = 1'b0; bus_ack_i = 1'b0;
      @(negedge clk); check("rel_data", 64'(mem_data_o), 64'h11);
      step;

      // Zero-wait load
      step; mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h40;
      @(negedge clk); check("ld_stall0", 64'(mem_stallreq_o), 64'd1);
      step; bus_ack_i = 1'b1; bus_data_i = 32'hDEAD_BEEF;
      @(negedge clk); check("ld_stall1", 64'(mem_stallreq_o), 64'd1);
      check("ld_addr", 64'({bus_we_o, bus_addr_o}), 64'h40);
      step; bus_ack_i = 1'b0;
      @(negedge clk); check("ld_stall2", 64'(mem_stallreq_o), 64'd0);
      check("ld_data", 64'(mem_data_o), 64'hDEAD_BEEF);
      step; mem_ce_i = 1'b0;

      // Simultaneous store and fetch
      step; mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h100; mem_sel_i = 4'b0100;
      mem_data_i = 32'h00AB_0000; if_ce_i = 1'b1; if_addr_i = 32'h2000;
      @(negedge clk); check("ct_stalls", 64'({mem_stallreq_o, if_stallreq_o}), 64'd3);
      step; bus_ack_i = 1'b1; bus_data_i = 32'h9999_9999;
      @(negedge clk); check("ct_st_sel", 64'(bus_sel_o), 64'b0100);
      check("ct_st_addr", 64'({bus_we_o, bus_addr_o}), 64'h1_0000_0100);
      step; mem_ce_i = 1'b0; bus_ack_i = 1'b0;
      @(negedge clk); check("ct_if_stall_ddone", 64'(if_stallreq_o), 64'd1);
      step;
      @(negedge clk); check("ct_idle", 64'({bus_cyc_o, if_stallreq_o}), 64'b01);
      step; bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678;
      @(negedge clk); check("ct_if_addr", 64'({bus_sel_o, bus_addr_o}), 64'hF_0000_2000);
      step; bus_ack_i = 1'b0;
      @(negedge clk); check("ct_if_done", 64'({if_stallreq_o, if_data_o}), 64'h0_1234_5678);
      step; if_ce_i = 1'b0;

      // Ack arriving on the last allowed busy cycle
      step; mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h80; mem_sel_i = 4'hF;
      @(negedge clk);
      step;
      for (int k = 1; k < TO; k++) begin
         @(negedge clk); check("ws_hold", 64'({bus_cyc_o, bus_err_o, bus_addr_o}), 64'h2_0000_0080);
         step;
      end
      bus_ack_i = 1'b1; bus_data_i = 32'hCAFE_F00D;
      @(negedge clk);
      step; bus_ack_i = 1'b0; mem_ce_i = 1'b0;
      @(negedge clk); check("ws_done", 64'({bus_err_o, mem_data_o}), 64'h0_CAFE_F00D);
      step;

      // Watchdog abort with no ack
      step; mem_ce_i = 1'b1; mem_addr_i = 32'hC0;
      @(negedge clk);
      step;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!bus_cyc_o) break;
         n++;
         step;
      end
      check("to_busy_cycles", 64'(n), 64'(TO));
      check("to_err", 64'({bus_err_o, mem_stallreq_o}), 64'b10);
      check("to_data", 64'(mem_data_o), 64'd0);
      step; mem_ce_i = 1'b0;
      @(negedge clk); check("to_err_once", 64'(bus_err_o), 64'd0);

      // Flush during a fetch
      step; if_ce_i = 1'b1; if_addr_i = 32'h3000;
      @(negedge clk);
      step; flush_i = 1'b1;
      @(negedge clk);
      step; flush_i = 1'b0; bus_ack_i = 1'b1; bus_data_i = 32'hBAD0_BAD0;
      @(negedge clk); check("fl_still_busy", 64'(bus_cyc_o), 64'd1);
      step; bus_ack_i = 1'b0;
      @(negedge clk); check("fl_discard", 64'({bus_cyc_o, if_stallreq_o, if_data_o}), 64'h1_1234_5678);
      step; bus_ack_i = 1'b1; bus_data_i = 32'h55AA_55AA;
      @(negedge clk); check("fl_regrant", 64'(bus_cyc_o), 64'd1);
      step; if_ce_i = 1'b0; bus_ack_i = 1'b0;
      @(negedge clk); check("fl_new_data", 64'(if_data_o), 64'h55AA_55AA);

      // Flush in a DONE cycle inserts a drain cycle
      step; mem_ce_i = 1'b1; mem_addr_i = 32'h44; bus_ack_i = 1'b1; bus_data_i = 32'h7;
      @(negedge clk);
      step;
      @(negedge clk);
      step; flush_i = 1'b1; bus_ack_i = 1'b0;
      @(negedge clk); check("dr_done", 64'(mem_stallreq_o), 64'd0);
      step; flush_i = 1'b0;
      @(negedge clk); check("dr_drain", 64'({bus_cyc_o, mem_stallreq_o}), 64'b01);
      step;
      @(negedge clk); check("dr_idle", 64'(bus_cyc_o), 64'd0);
      step; bus_ack_i = 1'b1;
      @(negedge clk); check("dr_grant", 64'(bus_cyc_o), 64'd1);
      step; mem_ce_i = 1'b0; bus_ack_i = 1'b0;

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         step;
         rst        = ($urandom_range(0, 199) != 0);
         mem_ce_i   = 1'($urandom_range(0, 1));
         mem_we_i   = 1'($urandom_range(0, 1));
         mem_addr_i = $urandom();
         mem_sel_i  = 4'($urandom_range(0, 15));
         mem_data_i = $urandom();
         if_ce_i    = 1'($urandom_range(0, 1));
         if_addr_i  = $urandom();
         flush_i    = ($urandom_range(0, 9) == 0);
         bus_ack_i  = ($urandom_range(0, 2) == 0);
         bus_data_i = $urandom();
      end
      step;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares a single Wishbone-style memory port between instruction fetch (IF) and the MEM stage data access.
- Sequences each access as a multi-cycle bus transaction and raises per-requester stall requests into the pipeline control block until the data is ready.
- Sits between the MEM/IF stage outputs (ce, we, sel, addr, data) and the external SRAM/bus.
- Includes a watchdog that aborts hung transactions.

Parameters:
- TIMEOUT_CYCLES, 255: maximum bus cycles waited for bus_ack_i before the transaction is aborted; must be 1..255.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on a rising clk edge).
- if_ce_i  in  1  instruction fetch request.
- if_addr_i  in  ADDR_W  fetch address.
- if_data_o  out  DATA_W  fetched instruction.
- if_stallreq_o  out  1  stall request for IF.
- mem_ce_i  in  1  data access request from MEM stage.
- mem_we_i  in  1  1 = write; already masked by MEM on exception.
- mem_addr_i  in  ADDR_W  data address.
- mem_sel_i  in  4  byte select; bit3 = bits 31:24.
- mem_data_i  in  DATA_W  store data.
- mem_data_o  out  DATA_W  load data.
- mem_stallreq_o  out  1  stall request for MEM.
- flush_i  in  1  exception flush from the control block.
- bus_cyc_o, bus_stb_o  out  1  bus cycle and strobe; always asserted together.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  ADDR_W  bus address.
- bus_sel_o  out  4  bus byte select.
- bus_data_o  out  DATA_W  bus write data.
- bus_data_i  in  DATA_W  bus read data.
- bus_ack_i  in  1  bus acknowledge.
- bus_err_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE; the timeout counter clears; result registers clear.
  - All bus outputs go to 0; if_data_o = mem_data_o = 0; both stallreqs = 0; bus_err_o = 0.
- States: IDLE, D_BUSY, I_BUSY, D_DONE, I_DONE, DRAIN.
- IDLE:
  - Data request has priority, because the MEM instruction is older.
  - If flush_i: stay IDLE and grant nothing.
  - Else if mem_ce_i: latch mem_we/addr/sel/data into bus registers, go to D_BUSY.
  - Else if if_ce_i: latch if_addr with we=0 and sel=4'b1111, go to I_BUSY.
- D_BUSY / I_BUSY:
  - bus_cyc_o = bus_stb_o = 1; bus address, sel, we and data are held constant from registers.
  - The timeout counter increments each cycle.
  - On bus_ack_i: capture bus_data_i into the matching result register, drop cyc/stb on the next cycle, and go to D_DONE / I_DONE.
  - On counter == TIMEOUT_CYCLES with no ack: result = 0, pulse bus_err_o, go to D_DONE / I_DONE.
  - flush_i while busy: the bus cycle is NOT abandoned (no mid-cycle abort). Record a pending-flush flag; on ack or timeout go to IDLE instead of DONE and discard the result.
- D_DONE / I_DONE:
  - Exactly one cycle long.
  - The matching stallreq is 0 and the *_data_o register holds the result, so the pipeline advances.
  - Next state is IDLE, or DRAIN if flush_i is asserted in this cycle.
  - Result registers hold their value until the next capture.
- DRAIN: a one-cycle idle after flush, so a stale ce from the flushed stage is not granted; then IDLE.
- Stall rules (combinational from state and inputs):
  - mem_stallreq_o = mem_ce_i and not D_DONE.
  - if_stallreq_o = if_ce_i and not I_DONE.
  - Both are forced to 0 while rst==0.
- Latency: with zero-wait-state ack (ack in the first busy cycle), a request accepted in cycle N gives DONE in N+2 and is granted again earliest in N+3. Back-to-back accesses therefore take 3 cycles each.
- Simultaneous requests: data is served first, then IF in the IDLE that follows D_DONE. IF stalls throughout.
- bus_ack_i outside a busy state is ignored.
- Timeout counter: 8 bits, saturating; cleared on entry to a busy state.

Decomposition:
- Shared package:
  - state encoding constants.
  - `ChipEnable`, `WriteEnable`, `ZeroWord`, and the active-low reset level constant (`RstEnable` = 1'b0 for this block's reset).
  - DEFAULT_TIMEOUT.
- One natural sub-module: mem_bus_watchdog, holding the counter, clear, and expire output.

Test Plan:
- Reset: hold rst=0 for 3 cycles with mem_ce_i=1 -> all outputs 0, no bus_cyc_o; release -> D_BUSY on the first edge.
- Load: mem_ce_i=1, we=0, addr=0x0000_0040, ack one cycle later with bus_data_i=0xDEAD_BEEF:
  - mem_stallreq_o stays high for 2 cycles.
  - mem_data_o = 0xDEADBEEF when stallreq falls.
  - No IF grant during this period.
- Contention: if_ce_i=1 and mem_ce_i=1 (store of sel=4'b0100, data 0x00AB0000 to 0x100) in the same cycle:
  - The store is issued first with bus_sel_o = 0100.
  - The fetch is issued afterwards.
  - if_stallreq_o stays high until I_DONE.
- Wait states: ack delayed 5 cycles -> bus outputs stable for all 5 cycles, no bus_err_o.
- Timeout: TIMEOUT_CYCLES=4 with no ack -> bus_err_o pulses once after 4 busy cycles, mem_data_o=0, FSM returns through D_DONE.
- Flush: flush_i asserted mid-fetch:
  - The bus cycle completes on ack.
  - if_data_o is unchanged and there is no I_DONE cycle.
  - A DRAIN/IDLE cycle follows before the next grant.
